// File: rtl/video_pkg.sv
// Shared types and default luma coefficients for the monochrome tint/fade video path.
package video_pkg;

  typedef enum logic [2:0] {
    ModeColour  = 3'b000,
    ModeGreen   = 3'b001,
    ModeAmber   = 3'b010,
    ModeBw      = 3'b011,
    ModeRed     = 3'b100,
    ModeBlue    = 3'b101,
    ModeFuchsia = 3'b110,
    ModePurple  = 3'b111
  } gfx_mode_e;

  typedef enum logic [1:0] {
    StInit,
    StSteady,
    StFadeOut,
    StFadeIn
  } fade_state_e;

  // Rec.709 weights scaled by 2**LumaLf; they sum to exactly 2**LumaLf.
  localparam int unsigned LumaLf = 8;
  localparam int unsigned LumaKr = 54;
  localparam int unsigned LumaKg = 183;
  localparam int unsigned LumaKb = 19;

endpackage

// File: rtl/video_luma_calc.sv
// Pipeline stages 1-2: register the pixel, then compute saturated weighted luma
// alongside a delayed copy of the raw colour.
module video_luma_calc
  import video_pkg::*;
#(
  parameter int unsigned CW = 8,
  parameter int unsigned LF = LumaLf,
  parameter int unsigned KR = LumaKr,
  parameter int unsigned KG = LumaKg,
  parameter int unsigned KB = LumaKb
) (
  input  logic          clk_vid,
  input  logic          reset_n,
  input  logic          ce_pix,
  input  logic [CW-1:0] r_i,
  input  logic [CW-1:0] g_i,
  input  logic [CW-1:0] b_i,
  output logic [CW-1:0] luma_o,
  output logic [CW-1:0] r_raw_o,
  output logic [CW-1:0] g_raw_o,
  output logic [CW-1:0] b_raw_o
);

  localparam int unsigned SW     = CW + LF + 2;
  localparam int unsigned MaxVal = (2 ** CW) - 1;

  logic [CW-1:0] r_s1_q, g_s1_q, b_s1_q;
  logic [CW-1:0] r_s2_q, g_s2_q, b_s2_q;
  logic [CW-1:0] luma_q, luma_d;
  logic [SW-1:0] sum, shifted;

  always_comb begin
    sum = SW'(KR) * SW'(r_s1_q) + SW'(KG) * SW'(g_s1_q) + SW'(KB) * SW'(b_s1_q);
    shifted = sum >> LF;
    luma_d  = (shifted > SW'(MaxVal)) ? {CW{1'b1}} : shifted[CW-1:0];
  end

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_q <= '0;
      g_s1_q <= '0;
      b_s1_q <= '0;
      r_s2_q <= '0;
      g_s2_q <= '0;
      b_s2_q <= '0;
      luma_q <= '0;
    end else if (ce_pix) begin
      r_s1_q <= r_i;
      g_s1_q <= g_i;
      b_s1_q <= b_i;
      r_s2_q <= r_s1_q;
      g_s2_q <= g_s1_q;
      b_s2_q <= b_s1_q;
      luma_q <= luma_d;
    end
  end

  assign luma_o  = luma_q;
  assign r_raw_o = r_s2_q;
  assign g_raw_o = g_s2_q;
  assign b_raw_o = b_s2_q;

endmodule

// File: rtl/video_mono_tint_fader.sv
// Luma/tint mapper with a vsync-paced cross-fade through black on display-mode changes.
// Stages 3 (tint) and 4 (gain scale) live here; stages 1-2 are in video_luma_calc.
module video_mono_tint_fader
  import video_pkg::*;
#(
  parameter int unsigned CW      = 8,
  parameter int unsigned LF      = LumaLf,
  parameter int unsigned KR      = LumaKr,
  parameter int unsigned KG      = LumaKg,
  parameter int unsigned KB      = LumaKb,
  parameter int unsigned FADE_W  = 4,
  parameter int unsigned FLOOR   = 'h08,
  parameter int unsigned FLOOR_G = 'h0F,
  parameter int unsigned TINGE   = 'h01
) (
  input  logic          clk_vid,
  input  logic          reset_n,
  input  logic          ce_pix,
  input  logic          vsync,
  input  logic [2:0]    gfx_mode,
  input  logic [CW-1:0] R,
  input  logic [CW-1:0] G,
  input  logic [CW-1:0] B,
  output logic [CW-1:0] R_OUT,
  output logic [CW-1:0] G_OUT,
  output logic [CW-1:0] B_OUT,
  output logic [2:0]    mode_active,
  output logic          fading
);

  localparam int unsigned   PW         = CW + FADE_W + 1;
  localparam int unsigned   GainMaxInt = 2 ** FADE_W;
  localparam logic [FADE_W:0] GainMax  = GainMaxInt[FADE_W:0];
  localparam logic [FADE_W:0] GainOne  = {{FADE_W{1'b0}}, 1'b1};
  localparam logic [CW-1:0] FloorV     = FLOOR[CW-1:0];
  localparam logic [CW-1:0] FloorGV    = FLOOR_G[CW-1:0];
  localparam logic [CW-1:0] TingeV     = TINGE[CW-1:0];

  logic [CW-1:0] luma, r_raw, g_raw, b_raw;

  video_luma_calc #(
    .CW(CW),
    .LF(LF),
    .KR(KR),
    .KG(KG),
    .KB(KB)
  ) u_luma (
    .clk_vid (clk_vid),
    .reset_n (reset_n),
    .ce_pix  (ce_pix),
    .r_i     (R),
    .g_i     (G),
    .b_i     (B),
    .luma_o  (luma),
    .r_raw_o (r_raw),
    .g_raw_o (g_raw),
    .b_raw_o (b_raw)
  );

  function automatic logic [CW-1:0] fmax(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [CW-1:0] scale(input logic [CW-1:0] t, input logic [FADE_W:0] g);
    logic [PW-1:0] p;
    p = PW'(t) * PW'(g);
    return CW'(p >> FADE_W);
  endfunction

  fade_state_e     state_q, state_d;
  gfx_mode_e       mode_active_q, mode_active_d;
  logic [FADE_W:0] gain_q, gain_d;
  logic            vsync_q, vs_rise, fading_q;
  logic [CW-1:0]   tint_r_d, tint_g_d, tint_b_d;
  logic [CW-1:0]   tint_r_q, tint_g_q, tint_b_q;
  logic [CW-1:0]   r_out_q, g_out_q, b_out_q;

  assign vs_rise = vsync & ~vsync_q;

  // Tint follows mode_active, which only changes at gain 0, so the swap is never visible.
  always_comb begin
    logic [CW-1:0] m, h;
    m = luma;
    h = luma >> 1;
    tint_r_d = '0;
    tint_g_d = '0;
    tint_b_d = '0;
    unique case (mode_active_q)
      ModeColour:  begin tint_r_d = r_raw;         tint_g_d = g_raw;          tint_b_d = b_raw;         end
      ModeGreen:   begin tint_r_d = '0;            tint_g_d = fmax(m, FloorGV); tint_b_d = TingeV;      end
      ModeAmber:   begin tint_r_d = fmax(m, FloorV); tint_g_d = h;            tint_b_d = TingeV;        end
      ModeBw:      begin tint_r_d = m;             tint_g_d = m;              tint_b_d = m;             end
      ModeRed:     begin tint_r_d = fmax(m, FloorV); tint_g_d = '0;           tint_b_d = TingeV;        end
      ModeBlue:    begin tint_r_d = '0;            tint_g_d = h;              tint_b_d = fmax(m, FloorV); end
      ModeFuchsia: begin tint_r_d = fmax(m, FloorV); tint_g_d = '0;           tint_b_d = h;             end
      ModePurple:  begin tint_r_d = h;             tint_g_d = '0;             tint_b_d = fmax(m, FloorV); end
      default:     begin tint_r_d = '0;            tint_g_d = '0;             tint_b_d = '0;            end
    endcase
  end

  always_comb begin
    state_d       = state_q;
    gain_d        = gain_q;
    mode_active_d = mode_active_q;
    case (state_q)
      StInit: begin
        mode_active_d = gfx_mode_e'(gfx_mode);
        state_d       = StSteady;
      end
      StSteady: begin
        if (gfx_mode != mode_active_q) state_d = StFadeOut;
      end
      StFadeOut: begin
        if (gfx_mode == mode_active_q) begin
          state_d = StFadeIn;
        end else if (gain_q == '0) begin
          // Reachable only when a fade-in at gain 0 is reversed again.
          mode_active_d = gfx_mode_e'(gfx_mode);
          state_d       = StFadeIn;
        end else if (vs_rise) begin
          gain_d = gain_q - GainOne;
          if (gain_q == GainOne) begin
            mode_active_d = gfx_mode_e'(gfx_mode);
            state_d       = StFadeIn;
          end
        end
      end
      StFadeIn: begin
        if (gfx_mode != mode_active_q) begin
          state_d = StFadeOut;
        end else if (gain_q == GainMax) begin
          state_d = StSteady;
        end else if (vs_rise) begin
          gain_d = gain_q + GainOne;
          if (gain_q == GainMax - GainOne) state_d = StSteady;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StInit;
      gain_q        <= GainMax;
      mode_active_q <= ModeColour;
      vsync_q       <= 1'b0;
      fading_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      gain_q        <= gain_d;
      mode_active_q <= mode_active_d;
      vsync_q       <= vsync;
      fading_q      <= (state_d == StFadeOut) || (state_d == StFadeIn);
    end
  end

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      tint_r_q <= '0;
      tint_g_q <= '0;
      tint_b_q <= '0;
      r_out_q  <= '0;
      g_out_q  <= '0;
      b_out_q  <= '0;
    end else if (ce_pix) begin
      tint_r_q <= tint_r_d;
      tint_g_q <= tint_g_d;
      tint_b_q <= tint_b_d;
      r_out_q  <= scale(tint_r_q, gain_q);
      g_out_q  <= scale(tint_g_q, gain_q);
      b_out_q  <= scale(tint_b_q, gain_q);
    end
  end

  assign R_OUT       = r_out_q;
  assign G_OUT       = g_out_q;
  assign B_OUT       = b_out_q;
  assign mode_active = mode_active_q;
  assign fading      = fading_q;

endmodule

// File: tb/tb_video_mono_tint_fader.sv
// Directed bench for video_mono_tint_fader at CW=8, FADE_W=2 with default coefficients.
module tb_video_mono_tint_fader;

  logic       clk_vid;
  logic       reset_n;
  logic       ce_pix;
  logic       vsync;
  logic [2:0] gfx_mode;
  logic [7:0] R, G, B;
  logic [7:0] R_OUT, G_OUT, B_OUT;
  logic [2:0] mode_active;
  logic       fading;

  int vectors    = 0;
  int miscompares = 0;

  video_mono_tint_fader #(
    .CW     (8),
    .FADE_W (2)
  ) dut (
    .clk_vid     (clk_vid),
    .reset_n     (reset_n),
    .ce_pix      (ce_pix),
    .vsync       (vsync),
    .gfx_mode    (gfx_mode),
    .R           (R),
    .G           (G),
    .B           (B),
    .R_OUT       (R_OUT),
    .G_OUT       (G_OUT),
    .B_OUT       (B_OUT),
    .mode_active (mode_active),
    .fading      (fading)
  );

  initial begin
    clk_vid = 1'b0;
    forever #5 clk_vid = ~clk_vid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_vid);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rgb(input string tag, input logic [7:0] er, input logic [7:0] eg,
                           input logic [7:0] eb);
    check({tag, ".R"}, {24'h0, R_OUT}, {24'h0, er});
    check({tag, ".G"}, {24'h0, G_OUT}, {24'h0, eg});
    check({tag, ".B"}, {24'h0, B_OUT}, {24'h0, eb});
  endtask

  // One vs_rise, then enough clocks for the new gain to reach the output stage.
  task automatic vs_pulse();
    vsync = 1'b1;
    tick(1);
    vsync = 1'b0;
    tick(6);
  endtask

  task automatic fade_to(input logic [2:0] mode);
    gfx_mode = mode;
    tick(2);
    repeat (8) vs_pulse();
    tick(4);
  endtask

  initial begin
    reset_n  = 1'b0;
    ce_pix   = 1'b0;
    vsync    = 1'b0;
    gfx_mode = 3'b001;
    {R, G, B} = 24'h000000;

    // Reset with ce_pix toggling.
    for (int i = 0; i < 6; i++) begin
      ce_pix = ~ce_pix;
      R      = 8'(i * 37);
      tick(1);
    end
    check_rgb("reset_out", 8'h00, 8'h00, 8'h00);
    check("reset_fading", {31'h0, fading}, 32'h0);
    check("reset_mode", {29'h0, mode_active}, 32'h0);

    R = 8'h00;
    ce_pix = 1'b1;
    reset_n = 1'b1;
    tick(1);
    check("init_mode", {29'h0, mode_active}, 32'h1);
    check("init_fading0", {31'h0, fading}, 32'h0);

    // Green, black input: floor on G, blue tinge.
    tick(6);
    check("init_fading1", {31'h0, fading}, 32'h0);
    check_rgb("green_black", 8'h00, 8'h0F, 8'h01);

    // B&W, white input.
    {R, G, B} = 24'hFFFFFF;
    fade_to(3'b011);
    check("bw_mode", {29'h0, mode_active}, 32'h3);
    check("bw_fading", {31'h0, fading}, 32'h0);
    check_rgb("bw_white", 8'hFF, 8'hFF, 8'hFF);

    // Amber, white input.
    fade_to(3'b010);
    check_rgb("amber_white", 8'hFF, 8'h7F, 8'h01);

    // ce_pix low freezes the datapath.
    ce_pix = 1'b0;
    for (int i = 0; i < 10; i++) begin
      {R, G, B} = 24'h123456 + 24'(i * 24'h010101);
      tick(1);
    end
    check_rgb("ce_hold", 8'hFF, 8'h7F, 8'h01);
    ce_pix = 1'b1;
    {R, G, B} = 24'hFFFFFF;
    tick(6);

    // Main fade: B&W -> green.
    fade_to(3'b011);
    gfx_mode = 3'b001;
    tick(2);
    check("fade_fading", {31'h0, fading}, 32'h1);
    check("fade_mode_hold", {29'h0, mode_active}, 32'h3);
    check("fade_g4", {24'h0, R_OUT}, 32'hFF);
    vs_pulse();
    check("fade_out_g3", {24'h0, R_OUT}, 32'hBF);
    vs_pulse();
    check("fade_out_g2", {24'h0, R_OUT}, 32'h7F);
    vs_pulse();
    check("fade_out_g1", {24'h0, R_OUT}, 32'h3F);
    vs_pulse();
    check("fade_out_g0", {24'h0, R_OUT}, 32'h00);
    check("fade_g0_G", {24'h0, G_OUT}, 32'h00);
    check("fade_switch", {29'h0, mode_active}, 32'h1);
    vs_pulse();
    check("fade_in_g1", {24'h0, G_OUT}, 32'h3F);
    vs_pulse();
    check("fade_in_g2", {24'h0, G_OUT}, 32'h7F);
    vs_pulse();
    check("fade_in_g3", {24'h0, G_OUT}, 32'hBF);
    check("fade_in_busy", {31'h0, fading}, 32'h1);
    vs_pulse();
    check("fade_in_g4", {24'h0, G_OUT}, 32'hFF);
    check("fade_done", {31'h0, fading}, 32'h0);
    check_rgb("green_white", 8'h00, 8'hFF, 8'h01);

    // Reversal at gain 2.
    gfx_mode = 3'b011;
    tick(2);
    vs_pulse();
    vs_pulse();
    check("rev_g2", {24'h0, G_OUT}, 32'h7F);
    gfx_mode = 3'b001;
    tick(2);
    vs_pulse();
    check("rev_g3", {24'h0, G_OUT}, 32'hBF);
    check("rev_mode", {29'h0, mode_active}, 32'h1);
    vs_pulse();
    check("rev_g4", {24'h0, G_OUT}, 32'hFF);
    check("rev_steady", {31'h0, fading}, 32'h0);

    // Reset mid-fade at gain 1.
    gfx_mode = 3'b011;
    tick(2);
    repeat (3) vs_pulse();
    check("mid_g1", {24'h0, G_OUT}, 32'h3F);
    reset_n = 1'b0;
    #1;
    check_rgb("mid_reset", 8'h00, 8'h00, 8'h00);
    check("mid_reset_fading", {31'h0, fading}, 32'h0);
    tick(3);
    reset_n = 1'b1;
    tick(8);
    check("post_mode", {29'h0, mode_active}, 32'h3);
    check("post_fading", {31'h0, fading}, 32'h0);
    check_rgb("post_full", 8'hFF, 8'hFF, 8'hFF);
    vs_pulse();
    check("post_still", {24'h0, G_OUT}, 32'hFF);
    check("post_no_fade", {31'h0, fading}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
